// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding, register offsets and CTRL field layout for timer_irq
package timer_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CNT = 2'd2, INT = 2'd3} state_t;
    localparam logic [1:0] OFF_CTRL     = 2'd0;
    localparam logic [1:0] OFF_PRESET   = 2'd1;
    localparam logic [1:0] OFF_COUNT    = 2'd2;
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;
endpackage

// File: rtl/timer_irq_if.sv
// timer_irq_if: word load/store bus from the data-memory bridge to the timer
interface timer_irq_if;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    modport master (output addr, we, wdata, input rdata);
    modport slave  (input addr, we, wdata, output rdata);
endinterface

// File: rtl/timer_irq.sv
// timer_irq: memory-mapped 32-bit down-counting timer raising irq on expiry, one-shot or auto-reload
module timer_irq
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    timer_irq_if.slave  bus,
    output logic        irq
);
    logic [3:0]  r_ctrl;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_flag;
    state_t      r_state;
    logic [1:0]  w_off;
    logic        w_hit;
    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_reload;
    logic        w_expire;
    logic        w_unused;
    assign w_off       = bus.addr[3:2];
    assign w_hit       = (bus.addr[31:4] == BASE_ADDR[31:4]) && (w_off != 2'b11);
    assign w_wr_ctrl   = w_hit && bus.we && (w_off == OFF_CTRL);
    assign w_wr_preset = w_hit && bus.we && (w_off == OFF_PRESET);
    assign w_reload    = r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD;
    assign w_expire    = (r_state == CNT) && r_ctrl[CTRL_EN] && (r_count <= 32'd1);
    assign w_unused    = ^bus.addr[1:0];
    assign irq         = r_flag & r_ctrl[CTRL_IM];
    assign bus.rdata   = !w_hit ? 32'h0 :
                         (w_off == OFF_CTRL)   ? {28'h0, r_ctrl} :
                         (w_off == OFF_PRESET) ? r_preset : r_count;
    // A CPU write to CTRL overrides INT's hardware EN clear; an expiry set overrides a CTRL-write flag clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctrl   <= '0;
            r_preset <= '0;
            r_count  <= '0;
            r_flag   <= 1'b0;
            r_state  <= IDLE;
        end else begin
            if (w_wr_preset) r_preset <= bus.wdata;
            if (w_wr_ctrl) r_ctrl <= bus.wdata[3:0];
            else if (r_state == INT && !w_reload) r_ctrl[CTRL_EN] <= 1'b0;
            if (w_expire) r_flag <= 1'b1;
            else if (w_wr_ctrl || (r_state == INT && w_reload)) r_flag <= 1'b0;
            case (r_state)
                IDLE: if (r_ctrl[CTRL_EN]) r_state <= LOAD;
                LOAD: begin
                    r_count <= r_preset;
                    r_state <= CNT;
                end
                CNT: begin
                    if (!r_ctrl[CTRL_EN]) r_state <= IDLE;
                    else if (w_expire) begin
                        r_count <= '0;
                        r_state <= INT;
                    end else r_count <= r_count - 32'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_timer_irq.sv
// tb_timer_irq: directed and random bus traffic checked every cycle against a timeline model of the timer
module tb_timer_irq;
    localparam logic [31:0] BASE = 32'h0000_7F00;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic irq;
    timer_irq_if bus();
    timer_irq #(.BASE_ADDR(BASE)) dut (.clk(clk), .reset(reset), .bus(bus), .irq(irq));
    always #5 clk = ~clk;
    int n_cmp = 0;
    int n_bad = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask
    // Model: a run starts on the edge IDLE sees EN; edge offsets from that start decide load/count/expire/end
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset, m_count;
    logic        m_flag, m_act;
    longint      m_cyc, m_start, m_n;
    function automatic logic m_hit(input logic [31:0] a);
        return (a[31:4] == BASE[31:4]) && (a[3:2] != 2'b11);
    endfunction
    function automatic logic [31:0] m_rd(input logic [31:0] a);
        if (!m_hit(a)) return 32'h0;
        case (a[3:2])
            2'd0: return {28'h0, m_ctrl};
            2'd1: return m_preset;
            default: return m_count;
        endcase
    endfunction
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ctrl = '0; m_preset = '0; m_count = '0; m_flag = 0; m_act = 0;
            m_cyc = 0; m_start = 0; m_n = 0;
        end else begin
            logic [3:0]  nctrl;
            logic [31:0] ncount;
            logic        nflag, nact, set, en, rl, wr;
            longint      d;
            nctrl = m_ctrl; ncount = m_count; nflag = m_flag; nact = m_act; set = 0;
            en = m_ctrl[0];
            rl = (m_ctrl[2:1] == 2'b01);
            wr = m_hit(bus.addr) && bus.we;
            m_cyc++;
            if (!m_act) begin
                if (en) begin nact = 1; m_start = m_cyc; end
            end else begin
                d = m_cyc - m_start;
                if (d == 1) begin
                    ncount = m_preset;
                    m_n = (m_preset == 0) ? 1 : longint'(m_preset);
                end else if (d <= m_n + 1) begin
                    if (!en) nact = 0;
                    else if (d <= m_n) ncount = 32'(m_n - (d - 1));
                    else begin ncount = 0; nflag = 1; set = 1; end
                end else begin
                    nact = 0;
                    if (rl) nflag = 0;
                    else nctrl[0] = 1'b0;
                end
            end
            if (wr && bus.addr[3:2] == 2'd0) begin
                nctrl = bus.wdata[3:0];
                if (!set) nflag = 0;
            end
            if (wr && bus.addr[3:2] == 2'd1) m_preset = bus.wdata;
            m_ctrl = nctrl; m_count = ncount; m_flag = nflag; m_act = nact;
        end
    end
    always @(negedge clk) begin
        chk("rdata", bus.rdata, m_rd(bus.addr));
        chk("irq", {31'h0, irq}, {31'h0, m_flag & m_ctrl[3]});
    end
    task automatic sync();
        @(posedge clk); #1;
    endtask
    task automatic cyc_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.addr = a; bus.we = 1'b1; bus.wdata = d;
        @(posedge clk); #1;
        bus.we = 1'b0; bus.addr = BASE + 32'h8;
    endtask
    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.addr = a; #1;
        d = bus.rdata;
        bus.addr = BASE + 32'h8;
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end
    initial begin
        logic [31:0] v, c1;
        int k, t[$];
        logic hi, moved, found;
        bus.addr = BASE + 32'h8; bus.we = 1'b0; bus.wdata = '0;
        #12 reset = 1'b1;
        sync();
        wr(BASE + 32'h4, 32'd8);
        wr(BASE, 32'h1);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (bus.rdata == 32'd5) found = 1; else sync();
        end
        chk("reset_reach5", {31'h0, found}, 32'h1);
        #1 reset = 1'b0;
        rd(BASE, v);          chk("rst_ctrl", v, 32'h0);
        rd(BASE + 32'h4, v);  chk("rst_preset", v, 32'h0);
        rd(BASE + 32'h8, v);  chk("rst_count", v, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        #1 reset = 1'b1;
        cyc_n(10);
        rd(BASE + 32'h8, v);  chk("post_rst_count", v, 32'h0);
        rd(BASE, v);          chk("post_rst_ctrl", v, 32'h0);
        wr(BASE + 32'h4, 32'd3);
        wr(BASE, 32'h9);
        for (k = 1; k <= 20; k++) begin
            sync();
            if (irq) break;
        end
        chk("oneshot_latency", k, 32'd5);
        cyc_n(3);
        chk("oneshot_hold", {31'h0, irq}, 32'h1);
        rd(BASE, v);          chk("oneshot_ctrl", v, 32'h8);
        wr(BASE, 32'h8);
        chk("oneshot_clear", {31'h0, irq}, 32'h0);
        wr(BASE + 32'h4, 32'd2);
        wr(BASE, 32'hB);
        for (int c = 0; c < 40; c++) begin
            sync();
            if (irq) t.push_back(c);
        end
        chk("reload_pulses", {31'h0, t.size() >= 4}, 32'h1);
        for (int i = 1; i < t.size(); i++) chk("reload_period", t[i] - t[i-1], 32'd5);
        wr(BASE, 32'h3);
        hi = 0; moved = 0; c1 = bus.rdata;
        for (int i = 0; i < 20; i++) begin
            sync();
            hi |= irq;
            if (bus.rdata != c1) moved = 1;
        end
        chk("masked_irq", {31'h0, hi}, 32'h0);
        chk("masked_count_moves", {31'h0, moved}, 32'h1);
        wr(BASE, 32'h0);
        cyc_n(6);
        wr(BASE + 32'h4, 32'd10);
        wr(BASE, 32'h9);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            sync();
            if (bus.rdata == 32'd6) found = 1;
        end
        chk("disable_reach6", {31'h0, found}, 32'h1);
        wr(BASE, 32'h8);
        cyc_n(2);
        c1 = bus.rdata; hi = 0;
        for (int i = 0; i < 20; i++) begin
            sync();
            hi |= irq;
        end
        chk("disable_frozen", bus.rdata, c1);
        chk("disable_5or6", {31'h0, (c1 == 32'd5) || (c1 == 32'd6)}, 32'h1);
        chk("disable_no_irq", {31'h0, hi}, 32'h0);
        rd(BASE + 32'h8, c1);
        wr(BASE + 32'h8, 32'd123);
        rd(BASE + 32'h8, v);  chk("count_write_ignored", v, c1);
        rd(BASE + 32'hC, v);  chk("rd_offC", v, 32'h0);
        wr(BASE + 32'hC, 32'hFFFF_FFFF);
        rd(BASE, v);          chk("offC_ctrl", v, 32'h8);
        rd(BASE + 32'h4, v);  chk("offC_preset", v, 32'd10);
        rd(BASE + 32'h10, v); chk("rd_off10", v, 32'h0);
        wr(BASE, 32'hFFFF_FFFF);
        rd(BASE, v);          chk("ctrl_mask", v, 32'hF);
        wr(BASE, 32'h0);
        cyc_n(6);
        wr(BASE + 32'h4, 32'd0);
        wr(BASE, 32'h9);
        for (k = 1; k <= 20; k++) begin
            sync();
            if (irq) break;
        end
        chk("preset0_latency", k, 32'd3);
        wr(BASE, 32'h0);
        cyc_n(4);
        wr(BASE + 32'h4, 32'hFFFF_FFFF);
        wr(BASE, 32'h1);
        cyc_n(2);
        chk("max_first", bus.rdata, 32'hFFFF_FFFF);
        cyc_n(10);
        chk("max_dec", bus.rdata, 32'hFFFF_FFF5);
        wr(BASE, 32'h0);
        cyc_n(4);
        for (int i = 0; i < 3000; i++) begin
            int sel;
            sel = $urandom_range(0, 5);
            bus.addr = (sel == 5) ? $urandom : BASE + 32'(sel * 4);
            bus.we = ($urandom_range(0, 5) == 0);
            bus.wdata = $urandom;
            if (sel == 1) bus.wdata = $urandom_range(0, 12);
            sync();
        end
        bus.we = 1'b0;
        sync();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/timer_irq.md
Name: timer_irq

Overview:
- Memory-mapped 32-bit down-counting timer. It is the interrupt source that drives one bit of the CPU's HWInt bus, which feeds the coprocessor-0 interrupt request logic.
- Software programs it through the CPU's data-memory bridge with word loads and stores.
- It raises `irq` when the count expires, either one-shot or auto-reload.

Parameters:
- BASE_ADDR, 32'h0000_7F00, word-aligned base address. Registers occupy BASE_ADDR+0x0, +0x4 and +0x8.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- addr  in  32  byte address from the bridge; bits [1:0] are ignored.
- we  in  1  word write strobe; effective only on an address hit.
- wdata  in  32  write data.
- rdata  out  32  combinational read data.
- irq  out  1  interrupt request to HWInt.

Behaviour:
- Address decode:
  - hit = (addr[31:4] == BASE_ADDR[31:4]) and (addr[3:2] != 2'b11).
  - Offset 0 is CTRL, offset 1 is PRESET, offset 2 is COUNT.
  - rdata = selected register on a hit, else 32'h0.
- CTRL fields:
  - [0] EN: enable.
  - [2:1] MODE: 00 = one-shot, 01 = auto-reload; 10 and 11 behave as 00.
  - [3] IM: interrupt mask.
  - [31:4] read as 0; writes to them are discarded.
- PRESET: read/write, all 32 bits.
- COUNT: read-only; writes are ignored.
- Reset (while reset==0, asynchronous):
  - CTRL, PRESET, COUNT and irq_flag = 0; state = IDLE.
  - rdata follows decode (0 for CTRL/PRESET/COUNT); irq = 0.
  - Deasserting reset mid-count gives a clean IDLE with no pending irq.
- FSM states: IDLE, LOAD, CNT, INT, in a 2-bit encoding. All transitions happen on the clk edge.
  - IDLE: if EN then go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If !EN: go to IDLE; COUNT holds.
    - Else if COUNT > 1: COUNT <= COUNT-1.
    - Else (COUNT is 0 or 1): COUNT <= 0, irq_flag <= 1, go to INT.
  - INT:
    - MODE one-shot: EN <= 0; irq_flag stays 1.
    - MODE auto-reload: irq_flag <= 0 (a one-cycle pulse), EN unchanged.
    - Go to IDLE in both cases.
- irq = irq_flag & CTRL.IM. This is registered-flag based, so there is no combinational path from the bus to irq.
- Clearing the one-shot flag: irq_flag is cleared by any CPU write to CTRL. A write to PRESET does not clear it.
- Latency:
  - With PRESET = N, irq_flag rises N+2 edges after the edge that writes EN=1 (N=0 behaves as N=1: 3 edges).
  - Auto-reload period is N+3 cycles, INT to INT.
- Simultaneous events:
  - A CPU write to CTRL in the same cycle as INT's hardware clear of EN: the CPU write wins for all CTRL bits, and irq_flag is cleared.
  - A CPU write to CTRL in the same cycle that CNT sets irq_flag: the set wins.
  - Writing PRESET during CNT does not affect the current count; it is used at the next LOAD.
  - Writing EN=0 during CNT: the FSM leaves for IDLE on the next edge and COUNT freezes at its current value.
- Address-hit writes with addr[3:2]==11 are ignored.

Decomposition:
- Shared package timer_pkg holds:
  - state encoding: IDLE=2'd0, LOAD=2'd1, CNT=2'd2, INT=2'd3;
  - register offsets: OFF_CTRL=2'd0, OFF_PRESET=2'd1, OFF_COUNT=2'd2;
  - MODE codes: MODE_ONESHOT=2'b00, MODE_RELOAD=2'b01;
  - CTRL bit indices: EN=0, MODE=2:1, IM=3.
- Single module, no sub-module. The register file and FSM are small and tightly coupled through EN.

Test Plan:
- Reset value check: assert reset=0 mid-count (COUNT=5, state CNT), then release.
  - Required: CTRL=PRESET=COUNT=0, irq=0, and no restart without a new write.
- One-shot:
  - Stimulus: write PRESET=3, then CTRL=32'h9 (EN, IM, one-shot).
  - Required: irq rises exactly 5 edges after the CTRL write and stays 1; CTRL reads 32'h8.
  - Then write CTRL=32'h8: irq falls on the next edge.
- Auto-reload:
  - Stimulus: PRESET=2, CTRL=32'hB.
  - Required: irq is a one-cycle pulse every 5 cycles, for at least 4 periods.
  - With CTRL=32'h3 (IM=0): COUNT still cycles and irq stays 0.
- Disable mid-count:
  - Stimulus: PRESET=10, CTRL=32'h9; after COUNT reads 6, write CTRL=32'h8.
  - Required: COUNT freezes at 5 or 6 (per edge alignment, checked against the model), and irq never asserts.
- Bus corner cases:
  - A write to COUNT (addr BASE+8) is ignored.
  - Read/write at BASE+0xC, and a read at BASE+0x10, return 0 with no state change.
  - Writing CTRL=32'hFFFF_FFFF reads back 32'hF.
- Boundary PRESET:
  - PRESET=0 with CTRL=32'h9: irq after 3 edges.
  - PRESET=32'hFFFF_FFFF: COUNT decrements with no wrap (sampled), and the first read after LOAD is 32'hFFFF_FFFF.
